// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR+R) between I and D requesters, one transaction in flight; round-robin, or fixed D priority when AXI_RD_DATA_PRIO_EN is defined
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [3:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  output logic              i_arready,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              i_rready,
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [3:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  output logic              d_arready,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_rlast,
  input  logic              d_rready,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [3:0]        m_rid,
  input  logic [31:0]       m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy,
  output logic              burst_err
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state;
  logic g, lg, cool, win_d, req, match, hs;
  logic [3:0] cnt;
  always_comb begin
`ifdef AXI_RD_DATA_PRIO_EN
    win_d = d_arvalid;
`else
    win_d = d_arvalid & (~i_arvalid | ~lg);
`endif
    req = ~reset & (state == IDLE) & ~cool & (i_arvalid | d_arvalid);
    i_arready = req & ~win_d;
    d_arready = req & win_d;
    match = ~reset & (state == R) & m_rvalid & (m_rid == m_arid);
    m_rready = ~reset & (state == R) & (g ? d_rready : i_rready);
    hs = match & m_rready;
    i_rvalid = match & ~g;
    d_rvalid = match & g;
    i_rdata = m_rdata;
    d_rdata = m_rdata;
    i_rlast = m_rlast;
    d_rlast = m_rlast;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g <= 1'b0;
      lg <= 1'b1;
      cool <= 1'b0;
      cnt <= 4'd0;
      m_arid <= 4'd0;
      m_araddr <= '0;
      m_arlen <= 4'd0;
      m_arsize <= 3'd0;
      m_arvalid <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      cool <= 1'b0;
      burst_err <= 1'b0;
      if (req) begin
        g <= win_d;
        lg <= win_d;
        m_arid <= win_d ? DATA_ID : INST_ID;
        m_araddr <= win_d ? d_araddr : i_araddr;
        m_arlen <= win_d ? d_arlen : i_arlen;
        m_arsize <= win_d ? d_arsize : i_arsize;
        m_arvalid <= 1'b1;
        state <= AR;
      end else if (state == AR) begin
        cnt <= 4'd0;
        if (m_arready) begin
          m_arvalid <= 1'b0;
          state <= R;
        end
      end else if (hs) begin
        cnt <= cnt + 4'd1;
        if (m_rlast) begin
          state <= IDLE;
          cool <= 1'b1;
          burst_err <= cnt != m_arlen;
        end
      end
    end
  end
endmodule
